// File: rtl/vpu_cmd_issuer.sv
// CPU-to-VPU command issuer: queues CPU commands, issues them one at a time to
// matrix_top (or the background-colour register) and returns loadback words to the CPU.
module vpu_cmd_issuer #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] LDBACK_OP = 4'hF,
  parameter int         BUSY_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_cmd_push,
  input  logic                      i_cmd_fill,
  input  logic [1:0]                i_cmd_obj_type,
  input  logic [2:0]                i_cmd_color,
  input  logic [3:0]                i_cmd_op,
  input  logic [3:0]                i_cmd_code,
  input  logic [4:0]                i_cmd_obj_num,
  input  logic [143:0]              i_cmd_v,
  output logic                      o_cmd_full,
  output logic [$clog2(DEPTH):0]    o_cmd_count,
  output logic                      o_overflow,
  output logic                      o_idle,
  input  logic                      i_vpu_busy,
  input  logic                      i_vpu_data_we,
  input  logic [127:0]              i_vpu_ldback,
  output logic                      o_vpu_go,
  output logic                      o_vpu_fill,
  output logic [1:0]                o_vpu_obj_type,
  output logic [2:0]                o_vpu_color,
  output logic [3:0]                o_vpu_op,
  output logic [3:0]                o_vpu_code,
  output logic [4:0]                o_vpu_obj_num,
  output logic [143:0]              o_vpu_v,
  output logic                      o_lb_vld,
  output logic [127:0]              o_lb_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 163;
  localparam int BW = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GO, S_WAIT_RISE, S_WAIT_FALL, S_WAIT_LB
  } state_t;

  state_t          r_state, w_next;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   r_wait_cnt;
  logic            r_overflow, r_fill_cmd, r_fill_pulse, r_lb_vld;
  logic [1:0]      r_vpu_obj_type;
  logic [2:0]      r_vpu_color;
  logic [3:0]      r_vpu_op, r_vpu_code;
  logic [4:0]      r_vpu_obj_num;
  logic [143:0]    r_vpu_v;
  logic [127:0]    r_lb_data;
  logic            w_full, w_push, w_pop, w_is_ldback, w_timeout;
  logic [EW-1:0]   w_wr_entry, w_head;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = i_cmd_push && !w_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !i_vpu_busy;
  assign w_wr_entry  = {i_cmd_fill, i_cmd_obj_type, i_cmd_color, i_cmd_op,
                        i_cmd_code, i_cmd_obj_num, i_cmd_v};
  assign w_head      = r_mem[r_rd_ptr];
  assign w_is_ldback = (r_vpu_op == LDBACK_OP);
  assign w_timeout   = (r_wait_cnt == BW'(BUSY_WAIT - 1));

  // Storage array carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_wait_cnt     <= '0;
      r_overflow     <= 1'b0;
      r_fill_cmd     <= 1'b0;
      r_fill_pulse   <= 1'b0;
      r_vpu_obj_type <= '0;
      r_vpu_color    <= '0;
      r_vpu_op       <= '0;
      r_vpu_code     <= '0;
      r_vpu_obj_num  <= '0;
      r_vpu_v        <= '0;
      r_lb_vld       <= 1'b0;
      r_lb_data      <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (i_cmd_push && w_full) r_overflow <= 1'b1;
      if (w_pop) begin
        r_fill_cmd     <= w_head[162];
        r_vpu_obj_type <= w_head[161:160];
        r_vpu_color    <= w_head[159:157];
        r_vpu_op       <= w_head[156:153];
        r_vpu_code     <= w_head[152:149];
        r_vpu_obj_num  <= w_head[148:144];
        r_vpu_v        <= w_head[143:0];
      end
      // Fill pulse is registered so it lands on the same cycle a go pulse would.
      r_fill_pulse <= (r_state == S_LOAD) && r_fill_cmd;
      if (r_state == S_GO)             r_wait_cnt <= '0;
      else if (r_state == S_WAIT_RISE) r_wait_cnt <= r_wait_cnt + BW'(1);
      r_lb_vld <= i_vpu_data_we;
      if (i_vpu_data_we) r_lb_data <= i_vpu_ldback;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_next = S_LOAD;
      S_LOAD:      w_next = r_fill_cmd ? S_IDLE : S_GO;
      S_GO:        w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (i_vpu_busy)     w_next = S_WAIT_FALL;
        else if (w_timeout) w_next = w_is_ldback ? S_WAIT_LB : S_IDLE;
      end
      S_WAIT_FALL: if (!i_vpu_busy) w_next = w_is_ldback ? S_WAIT_LB : S_IDLE;
      S_WAIT_LB:   if (i_vpu_data_we) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign o_cmd_full     = w_full;
  assign o_cmd_count    = r_count;
  assign o_overflow     = r_overflow;
  assign o_idle         = (r_count == '0) && (r_state == S_IDLE);
  assign o_vpu_go       = (r_state == S_GO);
  assign o_vpu_fill     = r_fill_pulse;
  assign o_vpu_obj_type = r_vpu_obj_type;
  assign o_vpu_color    = r_vpu_color;
  assign o_vpu_op       = r_vpu_op;
  assign o_vpu_code     = r_vpu_code;
  assign o_vpu_obj_num  = r_vpu_obj_num;
  assign o_vpu_v        = r_vpu_v;
  assign o_lb_vld       = r_lb_vld;
  assign o_lb_data      = r_lb_data;

endmodule

// File: tb/tb_vpu_cmd_issuer.sv
// Scoreboard bench for vpu_cmd_issuer: directed scenarios plus a randomized phase
// with an automatic busy/loadback responder.
module tb_vpu_cmd_issuer;

  localparam int         DEPTH     = 4;
  localparam logic [3:0] LDBACK_OP = 4'hF;
  localparam int         BUSY_WAIT = 8;

  typedef struct packed {
    logic         fill;
    logic [1:0]   ot;
    logic [2:0]   col;
    logic [3:0]   op;
    logic [3:0]   code;
    logic [4:0]   num;
    logic [143:0] v;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_cmd_push, i_cmd_fill;
  logic [1:0] i_cmd_obj_type;
  logic [2:0] i_cmd_color;
  logic [3:0] i_cmd_op, i_cmd_code;
  logic [4:0] i_cmd_obj_num;
  logic [143:0] i_cmd_v;
  logic o_cmd_full, o_overflow, o_idle;
  logic [$clog2(DEPTH):0] o_cmd_count;
  logic i_vpu_busy, i_vpu_data_we;
  logic [127:0] i_vpu_ldback;
  logic o_vpu_go, o_vpu_fill, o_lb_vld;
  logic [1:0] o_vpu_obj_type;
  logic [2:0] o_vpu_color;
  logic [3:0] o_vpu_op, o_vpu_code;
  logic [4:0] o_vpu_obj_num;
  logic [143:0] o_vpu_v;
  logic [127:0] o_lb_data;

  logic auto_mode, m_busy, m_we, a_busy, a_we;
  logic [127:0] m_lb, a_lb;

  assign i_vpu_busy    = auto_mode ? a_busy : m_busy;
  assign i_vpu_data_we = auto_mode ? a_we   : m_we;
  assign i_vpu_ldback  = auto_mode ? a_lb   : m_lb;

  vpu_cmd_issuer #(.DEPTH(DEPTH), .LDBACK_OP(LDBACK_OP), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_push(i_cmd_push), .i_cmd_fill(i_cmd_fill), .i_cmd_obj_type(i_cmd_obj_type),
    .i_cmd_color(i_cmd_color), .i_cmd_op(i_cmd_op), .i_cmd_code(i_cmd_code),
    .i_cmd_obj_num(i_cmd_obj_num), .i_cmd_v(i_cmd_v),
    .o_cmd_full(o_cmd_full), .o_cmd_count(o_cmd_count), .o_overflow(o_overflow),
    .o_idle(o_idle), .i_vpu_busy(i_vpu_busy), .i_vpu_data_we(i_vpu_data_we),
    .i_vpu_ldback(i_vpu_ldback), .o_vpu_go(o_vpu_go), .o_vpu_fill(o_vpu_fill),
    .o_vpu_obj_type(o_vpu_obj_type), .o_vpu_color(o_vpu_color), .o_vpu_op(o_vpu_op),
    .o_vpu_code(o_vpu_code), .o_vpu_obj_num(o_vpu_obj_num), .o_vpu_v(o_vpu_v),
    .o_lb_vld(o_lb_vld), .o_lb_data(o_lb_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, go_count = 0, issued = 0, pushed_acc = 0;
  cmd_t         exp_q[$];
  logic [127:0] exp_lb[$];
  int           go_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
  endtask

  // Monitor: every issue pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    cmd_t c;
    if (o_vpu_go || o_vpu_fill) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 256'({o_vpu_go, o_vpu_fill}), 256'(0));
      end else begin
        c = exp_q.pop_front();
        issued++;
        if (c.fill)
          check("fill_issue", 256'({o_vpu_fill, o_vpu_go, o_vpu_color}),
                256'({1'b1, 1'b0, c.col}));
        else
          check("go_issue", 256'({o_vpu_fill, o_vpu_go, o_vpu_obj_type, o_vpu_color,
                                  o_vpu_op, o_vpu_code, o_vpu_obj_num, o_vpu_v}),
                256'({1'b0, 1'b1, c.ot, c.col, c.op, c.code, c.num, c.v}));
      end
      if (o_vpu_go) begin
        go_count++;
        go_t.push_back(cyc);
      end
    end
    if (o_lb_vld) begin
      if (exp_lb.size() == 0) check("unexpected_lb_vld", 256'(o_lb_vld), 256'(0));
      else check("lb_data", 256'(o_lb_data), 256'(exp_lb.pop_front()));
    end
  end

  // Automatic responder: models matrix_top busy and video_mem_unit loadback.
  initial begin
    logic [3:0] op;
    bit never;
    a_busy = 1'b0; a_we = 1'b0; a_lb = '0;
    forever begin
      @(negedge clk);
      if (auto_mode && o_vpu_go) begin
        op = o_vpu_op;
        never = ($urandom_range(0, 3) == 0);
        if (!never) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a_busy = 1'b1;
          repeat ($urandom_range(1, 5)) @(negedge clk);
          a_busy = 1'b0;
        end else begin
          repeat (BUSY_WAIT + 1) @(negedge clk);
        end
        if (op == LDBACK_OP) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          for (int k = 0; k < 4; k++) a_lb[k*32 +: 32] = $urandom;
          exp_lb.push_back(a_lb);
          a_we = 1'b1;
          @(negedge clk);
          a_we = 1'b0;
        end
      end
    end
  end

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.fill = ($urandom_range(0, 4) == 0);
    c.ot   = 2'($urandom);
    c.col  = 3'($urandom);
    c.op   = ($urandom_range(0, 3) == 0) ? LDBACK_OP : 4'($urandom_range(0, 14));
    c.code = 4'($urandom);
    c.num  = 5'($urandom);
    for (int k = 0; k < 9; k++) c.v[k*16 +: 16] = 16'($urandom);
    return c;
  endfunction

  task automatic push_cmd(input cmd_t c, input bit accept);
    @(posedge clk); #1;
    i_cmd_push = 1'b1;
    {i_cmd_fill, i_cmd_obj_type, i_cmd_color, i_cmd_op, i_cmd_code, i_cmd_obj_num, i_cmd_v} = c;
    if (accept) begin
      exp_q.push_back(c);
      pushed_acc++;
    end
    @(posedge clk); #1;
    i_cmd_push = 1'b0;
  endtask

  task automatic wait_go(input string nm);
    int g0, k;
    g0 = go_count; k = 0;
    while (go_count == g0 && k < 100) begin @(negedge clk); k++; end
    check(nm, 256'(go_count != g0), 256'(1));
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!(o_idle && exp_q.size() == 0 && exp_lb.size() == 0) && k < maxc) begin
      @(negedge clk); k++;
    end
    check(nm, 256'({o_idle, 8'(exp_q.size()), 8'(exp_lb.size())}), 256'({1'b1, 8'd0, 8'd0}));
  endtask

  initial begin
    cmd_t c;
    int g0, n;
    rst_n = 1'b0; auto_mode = 1'b0; m_busy = 1'b0; m_we = 1'b0; m_lb = '0;
    i_cmd_push = 1'b0;
    {i_cmd_fill, i_cmd_obj_type, i_cmd_color, i_cmd_op, i_cmd_code, i_cmd_obj_num, i_cmd_v} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_status", 256'({o_idle, o_cmd_full, o_cmd_count, o_overflow}), 256'({1'b1, 1'b0, 3'd0, 1'b0}));
    check("rst_pulses", 256'({o_vpu_go, o_vpu_fill, o_lb_vld}), 256'(0));
    check("rst_fields", 256'({o_vpu_obj_type, o_vpu_color, o_vpu_op, o_vpu_code, o_vpu_obj_num, o_vpu_v}), 256'(0));
    check("rst_lb_data", 256'(o_lb_data), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // T1: go latency and idle after busy falls
    c = rand_cmd(); c.fill = 1'b0; c.op = 4'd1; c.num = 5'd3;
    g0 = go_count;
    push_cmd(c, 1'b1);
    @(negedge clk);                 check("t1_go_c1", 256'(o_vpu_go), 256'(0));
    @(posedge clk); @(negedge clk); check("t1_go_c2", 256'(o_vpu_go), 256'(0));
    @(posedge clk); @(negedge clk); check("t1_go_c3", 256'(o_vpu_go), 256'(1));
    @(posedge clk); #1 m_busy = 1'b1;
    repeat (10) @(posedge clk);
    #1 m_busy = 1'b0;
    @(negedge clk);                 check("t1_not_idle", 256'(o_idle), 256'(0));
    @(posedge clk); @(negedge clk); check("t1_idle", 256'(o_idle), 256'(1));
    check("t1_one_go", 256'(go_count - g0), 256'(1));

    // T2/T5: fill FIFO while busy, overflow, then timeouts issue in order
    @(posedge clk); #1 m_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c = rand_cmd(); c.fill = 1'b0; c.op = 4'(i);
      push_cmd(c, i < DEPTH);
      if (i == DEPTH - 1) check("t2_full", 256'({o_cmd_full, o_cmd_count}), 256'({1'b1, 3'd4}));
    end
    check("t2_overflow", 256'({o_overflow, o_cmd_count}), 256'({1'b1, 3'd4}));
    g0 = go_count;
    m_busy = 1'b0;
    wait_idle(300, "t2_drain");
    check("t2_go_count", 256'(go_count - g0), 256'(4));
    n = go_t.size();
    for (int i = 1; i < 4; i++)
      check("t5_timeout_spacing", 256'(go_t[n-i] - go_t[n-i-1]), 256'(BUSY_WAIT + 3));

    // T3: fill command, busy ignored after pop
    c = rand_cmd(); c.fill = 1'b1; c.col = 3'd5;
    g0 = go_count;
    push_cmd(c, 1'b1);
    @(posedge clk); #1 m_busy = 1'b1;
    @(negedge clk);                 check("t3_fill_c2", 256'(o_vpu_fill), 256'(0));
    @(posedge clk); @(negedge clk); check("t3_fill_c3", 256'({o_vpu_fill, o_vpu_color}), 256'({1'b1, 3'd5}));
    @(posedge clk); @(negedge clk); check("t3_fill_once", 256'({o_vpu_fill, o_idle}), 256'({1'b0, 1'b1}));
    m_busy = 1'b0;
    check("t3_no_go", 256'(go_count - g0), 256'(0));

    // T4: loadback
    c = rand_cmd(); c.fill = 1'b0; c.op = LDBACK_OP;
    push_cmd(c, 1'b1);
    wait_go("t4_go");
    @(posedge clk); #1 m_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1 m_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); check("t4_wait_lb", 256'(o_idle), 256'(0));
    @(posedge clk); #1;
    m_lb = {16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1};
    exp_lb.push_back(m_lb);
    m_we = 1'b1;
    @(posedge clk); #1 m_we = 1'b0; m_lb = '0;
    wait_idle(20, "t4_done");
    repeat (3) @(negedge clk);
    check("t4_lb_hold", 256'({o_lb_vld, o_lb_data}),
          256'({1'b0, 16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1}));

    // Randomized traffic with automatic responder
    auto_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int guard;
      guard = 0;
      while ((pushed_acc - issued) >= DEPTH && guard < 2000) begin @(posedge clk); guard++; end
      push_cmd(rand_cmd(), 1'b1);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    wait_idle(5000, "rand_drain");
    repeat (BUSY_WAIT + 6) @(posedge clk);
    auto_mode = 1'b0;

    // T6: reset mid-operation with two queued
    c = rand_cmd(); c.fill = 1'b0; c.op = 4'd2;
    push_cmd(c, 1'b1);
    wait_go("t6_go");
    @(posedge clk); #1 m_busy = 1'b1;
    push_cmd(rand_cmd(), 1'b1);
    push_cmd(rand_cmd(), 1'b1);
    @(negedge clk); check("t6_queued", 256'({o_cmd_count, o_idle}), 256'({3'd2, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    pushed_acc = issued;
    @(negedge clk);
    check("t6_rst_state", 256'({o_cmd_count, o_idle, o_vpu_go, o_overflow}), 256'({3'd0, 1'b1, 1'b0, 1'b0}));
    m_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    g0 = go_count;
    repeat (20) @(negedge clk);
    check("t6_no_go", 256'({8'(go_count - g0), o_idle}), 256'({8'd0, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
